// File: rtl/sdp_y_core_pkg.sv
// Shared types and constants for the SDP Y core channel blocks.
package sdp_y_core_pkg;

  localparam int SDP_Y_CORE_CHN_W = 128;
  localparam int SDP_Y_CORE_PERF_W = 32;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } chn_out_state_e;

endpackage

// File: rtl/sdp_y_core_chn_out_rsco_skid.sv
// Two-entry skid buffer for the outbound z/vz/lz channel; all outputs come
// straight from flops so downstream ready never reaches the core enable.
module sdp_y_core_chn_out_rsco_skid
  import sdp_y_core_pkg::*;
#(
  parameter int WIDTH = SDP_Y_CORE_CHN_W
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             core_wr,
  input  logic [WIDTH-1:0] core_d,
  input  logic             out_vz,
  output logic             wen_comp,
  output logic             out_lz,
  output logic [WIDTH-1:0] out_z
);

  chn_out_state_e   state;
  logic [WIDTH-1:0] head;
  logic [WIDTH-1:0] skid;
  logic             lz_q;
  logic             wen_q;
  logic             push;
  logic             pop;

  assign push = core_wr & wen_q;
  assign pop  = lz_q & out_vz;

  // lz and wen_comp are registered alongside state so they track it exactly.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= EMPTY;
      head  <= '0;
      skid  <= '0;
      lz_q  <= 1'b0;
      wen_q <= 1'b1;
    end else begin
      case (state)
        EMPTY: begin
          if (push) begin
            head  <= core_d;
            state <= ONE;
            lz_q  <= 1'b1;
            wen_q <= 1'b1;
          end
        end
        ONE: begin
          if (push && !pop) begin
            skid  <= core_d;
            state <= FULL;
            wen_q <= 1'b0;
          end else if (pop && !push) begin
            state <= EMPTY;
            lz_q  <= 1'b0;
          end else if (push && pop) begin
            head <= core_d;
          end
        end
        FULL: begin
          if (pop) begin
            head  <= skid;
            state <= ONE;
            wen_q <= 1'b1;
          end
        end
        default: begin
          state <= EMPTY;
          lz_q  <= 1'b0;
          wen_q <= 1'b1;
        end
      endcase
    end
  end

  assign wen_comp = wen_q;
  assign out_lz   = lz_q;
  assign out_z    = head;

endmodule

// File: rtl/sdp_y_core_chn_out_rsco.sv
// SDP Y core output-channel transmitter: skid buffer plus optional stall
// counter, enabled by defining SDP_Y_CORE_OUT_PERF_EN.
module sdp_y_core_chn_out_rsco
  import sdp_y_core_pkg::*;
#(
  parameter int WIDTH = SDP_Y_CORE_CHN_W
) (
  input  logic             nvdla_core_clk,
  input  logic             nvdla_core_rstn,
  input  logic             core_wr,
  input  logic [WIDTH-1:0] core_d,
  output logic             core_wen_comp,
  output logic [WIDTH-1:0] chn_out_rsc_z,
  output logic             chn_out_rsc_lz,
  input  logic             chn_out_rsc_vz,
  output logic [31:0]      perf_stall_cnt
);

  sdp_y_core_chn_out_rsco_skid #(
    .WIDTH (WIDTH)
  ) u_skid (
    .clk      (nvdla_core_clk),
    .rstn     (nvdla_core_rstn),
    .core_wr  (core_wr),
    .core_d   (core_d),
    .out_vz   (chn_out_rsc_vz),
    .wen_comp (core_wen_comp),
    .out_lz   (chn_out_rsc_lz),
    .out_z    (chn_out_rsc_z)
  );

`ifdef SDP_Y_CORE_OUT_PERF_EN
  logic [SDP_Y_CORE_PERF_W-1:0] stall_cnt;

  // Counts cycles where a word is offered but the consumer holds off; saturates.
  always_ff @(posedge nvdla_core_clk) begin
    if (!nvdla_core_rstn) begin
      stall_cnt <= '0;
    end else if (chn_out_rsc_lz && !chn_out_rsc_vz && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign perf_stall_cnt = stall_cnt;
`else
  assign perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_sdp_y_core_chn_out_rsco.sv
// Directed scoreboard bench for sdp_y_core_chn_out_rsco.
module tb_sdp_y_core_chn_out_rsco;
  import sdp_y_core_pkg::*;

  localparam int W = SDP_Y_CORE_CHN_W;

  logic         nvdla_core_clk;
  logic         nvdla_core_rstn;
  logic         core_wr;
  logic [W-1:0] core_d;
  logic         core_wen_comp;
  logic [W-1:0] chn_out_rsc_z;
  logic         chn_out_rsc_lz;
  logic         chn_out_rsc_vz;
  logic [31:0]  perf_stall_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [W-1:0] exp_q[$];
  int           model_cnt;
  logic [31:0]  model_stall;

  sdp_y_core_chn_out_rsco #(
    .WIDTH (W)
  ) dut (
    .nvdla_core_clk  (nvdla_core_clk),
    .nvdla_core_rstn (nvdla_core_rstn),
    .core_wr         (core_wr),
    .core_d          (core_d),
    .core_wen_comp   (core_wen_comp),
    .chn_out_rsc_z   (chn_out_rsc_z),
    .chn_out_rsc_lz  (chn_out_rsc_lz),
    .chn_out_rsc_vz  (chn_out_rsc_vz),
    .perf_stall_cnt  (perf_stall_cnt)
  );

  initial nvdla_core_clk = 1'b0;
  always #5 nvdla_core_clk = ~nvdla_core_clk;

  task automatic checkOutput(input string tag, input logic [W-1:0] observed,
                             input logic [W-1:0] expected);
    n_cmp++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkPerf();
    logic [31:0] exp_perf;
`ifdef SDP_Y_CORE_OUT_PERF_EN
    exp_perf = model_stall;
`else
    exp_perf = 32'd0;
`endif
    checkOutput("perf_stall_cnt", W'(perf_stall_cnt), W'(exp_perf));
  endtask

  // Called at a falling edge: drive one cycle, check the registered outputs
  // against the model, score any transfer, then advance the model past the edge.
  task automatic applyStimulus(input logic wr, input logic [W-1:0] d, input logic vz);
    logic do_push;
    logic do_pop;
    core_wr        = wr;
    core_d         = d;
    chn_out_rsc_vz = vz;
    #1;
    checkOutput("lz", W'(chn_out_rsc_lz), W'(model_cnt != 0));
    checkOutput("wen_comp", W'(core_wen_comp), W'(model_cnt != 2));
    checkPerf();
    if (model_cnt != 0) checkOutput("z_head", chn_out_rsc_z, exp_q[0]);
    do_push = wr && (model_cnt != 2);
    do_pop  = vz && (model_cnt != 0);
    if (do_pop) void'(exp_q.pop_front());
    if (do_push) exp_q.push_back(d);
    if ((model_cnt != 0) && !vz && (model_stall != 32'hFFFF_FFFF)) model_stall++;
    model_cnt = model_cnt + int'(do_push) - int'(do_pop);
    @(negedge nvdla_core_clk);
  endtask

  task automatic applyReset(input int cycles);
    core_wr         = 1'b0;
    nvdla_core_rstn = 1'b0;
    repeat (cycles) @(negedge nvdla_core_clk);
    nvdla_core_rstn = 1'b1;
    exp_q.delete();
    model_cnt   = 0;
    model_stall = 32'd0;
  endtask

  initial begin
    nvdla_core_rstn = 1'b0;
    core_wr         = 1'b0;
    core_d          = '0;
    chn_out_rsc_vz  = 1'b0;
    model_cnt       = 0;
    model_stall     = 32'd0;
    @(negedge nvdla_core_clk);

    // reset then idle
    applyReset(2);
    #1;
    checkOutput("rst_lz", W'(chn_out_rsc_lz), W'(1'b0));
    checkOutput("rst_wen", W'(core_wen_comp), W'(1'b1));
    checkOutput("rst_perf", W'(perf_stall_cnt), W'(32'd0));
    checkOutput("rst_z", chn_out_rsc_z, W'(0));
    @(negedge nvdla_core_clk);
    applyStimulus(1'b0, W'(0), 1'b0);

    // streaming at full rate
    for (int i = 1; i <= 8; i++) applyStimulus(1'b1, W'(i), 1'b1);
    applyStimulus(1'b0, W'(0), 1'b1);
    applyStimulus(1'b0, W'(0), 1'b1);

    // backpressure fill, overflow write ignored, then drain
    applyStimulus(1'b1, W'(32'hA), 1'b0);
    applyStimulus(1'b1, W'(32'hB), 1'b0);
    applyStimulus(1'b1, W'(32'hC), 1'b0);
    applyStimulus(1'b0, W'(0), 1'b0);
    applyStimulus(1'b0, W'(0), 1'b1);
    applyStimulus(1'b0, W'(0), 1'b1);
    applyStimulus(1'b0, W'(0), 1'b1);

    // push and pop together while holding one word
    applyStimulus(1'b1, W'(32'h5), 1'b1);
    applyStimulus(1'b1, W'(32'h6), 1'b1);
    applyStimulus(1'b0, W'(0), 1'b0);
    applyStimulus(1'b0, W'(0), 1'b1);
    applyStimulus(1'b0, W'(0), 1'b1);

    // reset while full discards both words
    applyStimulus(1'b1, W'(32'hA), 1'b0);
    applyStimulus(1'b1, W'(32'hB), 1'b0);
    applyReset(1);
    applyStimulus(1'b0, W'(0), 1'b1);
    applyStimulus(1'b0, W'(0), 1'b1);
    applyStimulus(1'b0, W'(0), 1'b1);

    // stall counter over ten backpressured cycles
    applyStimulus(1'b1, W'(32'h7), 1'b0);
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, W'(0), 1'b0);
    #1;
`ifdef SDP_Y_CORE_OUT_PERF_EN
    checkOutput("perf_ten", W'(perf_stall_cnt), W'(32'd10));
`else
    checkOutput("perf_ten", W'(perf_stall_cnt), W'(32'd0));
`endif
    @(negedge nvdla_core_clk);
    applyStimulus(1'b0, W'(0), 1'b1);
    applyStimulus(1'b0, W'(0), 1'b1);

    checkOutput("queue_drained", W'(exp_q.size()), W'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/sdp_y_core_chn_out_rsco.md
# sdp_y_core_chn_out_rsco

Output-channel transmitter for the SDP Y core: the transmit end of the same z/vz/lz channel protocol the core's input-channel receivers use. It takes one WIDTH-bit word per accepted core write, holds it in a 2-entry skid buffer, and presents it on the outbound channel until the downstream consumer signals ready. The core stall signal is registered-state-only, so there is no combinational path from downstream ready back into the core's enable logic.

## Interface
- WIDTH, 128, channel data width in bits.
- nvdla_core_clk  in  1  clock; all state updates on the rising edge.
- nvdla_core_rstn  in  1  reset, synchronous, active-low.
- core_wr  in  1  core presents a word this cycle.
- core_d  in  WIDTH  core write data.
- core_wen_comp  out  1  space available; a write is accepted when `core_wr & core_wen_comp`.
- chn_out_rsc_z  out  WIDTH  channel data, valid when lz=1.
- chn_out_rsc_lz  out  1  channel valid.
- chn_out_rsc_vz  in  1  downstream ready; a transfer occurs when `lz & vz`.
- perf_stall_cnt  out  32  count of backpressure cycles (see Configuration).

## Operation
- State: EMPTY (0 words), ONE (1 word, held in head), FULL (2 words, head plus skid).
- core_wen_comp = (state != FULL). It is a function of registered state only.
- push = core_wr & core_wen_comp; pop = chn_out_rsc_lz & chn_out_rsc_vz.
- Transitions:
  - EMPTY + push: go to ONE; head <= core_d.
  - ONE + push, no pop: go to FULL; skid <= core_d.
  - ONE + pop, no push: go to EMPTY.
  - ONE + push + pop: stay ONE; head <= core_d.
  - FULL + pop: go to ONE; head <= skid. No push can occur in FULL.
  - Any other combination: hold.
- chn_out_rsc_lz = (state != EMPTY). chn_out_rsc_z = head.
- While lz=1 and no pop occurs, z is held stable. This is a protocol requirement.
- Words leave in acceptance order. No word is dropped or duplicated.
- core_d is ignored when push=0. head and skid are not cleared on pop.

## Timing
- Reset values: state=EMPTY, lz=0, core_wen_comp=1, perf_stall_cnt=0. z is don't-care; it resets to 0 for determinism.
- Latency: a word accepted at edge N appears on z with lz=1 in cycle N+1, when the buffer was EMPTY or was ONE with a simultaneous pop.
- Throughput: 1 word/cycle sustained while vz=1 continuously.
- Full boundary: once FULL, core_wen_comp=0. The first pop re-asserts it in the following cycle.
- Empty boundary: a pop in ONE with no push drops lz in the next cycle.
- Reset mid-operation: buffered words are discarded. lz=0 and core_wen_comp=1 in the cycle after the reset edge.
- vz may toggle arbitrarily. lz never depends combinationally on vz.

## Configuration
- SDP_Y_CORE_OUT_PERF_EN defined:
  - perf_stall_cnt increments each cycle with lz=1 & vz=0.
  - It saturates at 32'hFFFF_FFFF and clears on reset.
- Not defined:
  - perf_stall_cnt is tied to 0.
  - No counter flops are generated.
  - The port remains present.

## Structure
- Shared package sdp_y_core_pkg holds:
  - the state enum {EMPTY, ONE, FULL} (2-bit encoding);
  - the default channel width constant SDP_Y_CORE_CHN_W=128.
- One sub-module: sdp_y_core_chn_out_rsco_skid.
  - It contains the state register, head/skid registers, and push/pop logic.
  - The top adds the port mapping and the optional perf counter.

## Test plan
- Reset then idle: after rstn low for 2 cycles, expect lz=0, core_wen_comp=1, perf_stall_cnt=0.
- Streaming: vz=1 held, push words 0x1..0x8 on consecutive cycles.
  - Expect z=0x1..0x8 on consecutive cycles starting one cycle after the first push.
  - Expect core_wen_comp to stay 1 throughout.
- Backpressure fill: vz=0, push 0xA then 0xB.
  - Expect state FULL and core_wen_comp=0.
  - A third write 0xC is ignored.
  - z stays 0xA while vz=0.
  - Raise vz: expect 0xA then 0xB, then lz=0.
- Simultaneous push and pop in ONE: head=0x5 with vz=1 and push 0x6 in the same cycle.
  - Expect z=0x6 next cycle, lz stays 1, no gap.
- Reset mid-operation: FULL with 0xA and 0xB, assert rstn=0 for one cycle.
  - Expect lz=0 and core_wen_comp=1 after the edge.
  - Neither word is ever transmitted.
- Perf counter (macro defined): hold lz=1 and vz=0 for 10 cycles.
  - Expect perf_stall_cnt=10.
  - Without the macro, expect 0.
